mux_comportamental: RTL and testbench
=====================================

// Module: mux_comportamental
// PURPOSE
//  - Behavioural 4:1 multiplexer for datapath lane selection in the practical-lab datapath.
//  - Select input S routes one bit of D to the combinational output Y, which always follows the inputs.
//  - A registered copy Y_q with enable provides a glitch-free, clocked version for downstream synchronous logic.
//  - Registered status flag sel_q records the select that produced Y_q.
// PARAMETERS
//  N_SEL    2    select width; number of data inputs = 2**N_SEL (default 4)
//  DATA_W   1    width of each data lane; D packs lanes LSB-first
//  RST_VAL  0    value of Y_q after reset (DATA_W bits, replicated)
// PORTS
//  clk    in   1                    rising-edge clock for registered outputs
//  rst_n  in   1                    asynchronous, active-low reset
//  D      in   DATA_W*2**N_SEL      data lanes; lane i = D[i*DATA_W +: DATA_W]
//  S      in   N_SEL                lane select
//  en     in   1                    capture enable for Y_q/sel_q
//  Y      out  DATA_W               combinational selected lane
//  Y_q    out  DATA_W               registered selected lane
//  sel_q  out  N_SEL                select value captured with Y_q
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Y = lane S of D, purely combinational, zero latency; not affected by clk, rst_n or en.
//  - Default config: S=00->D[0], 01->D[1], 10->D[2], 11->D[3].
//  - S containing X/Z: Y = all X in simulation. Synthesis: no latch, full case.
//  - Y_q/sel_q: while rst_n=0 -> Y_q=RST_VAL, sel_q=0, asserted immediately (async).
//  - Rising clk with rst_n=1 and en=1: Y_q<=lane S of D, sel_q<=S (1-cycle latency vs Y).
//  - en=0: Y_q, sel_q hold.
//  - Reset asserted mid-operation overrides en; release is synchronous to the next edge
//    (first capture happens on the first rising edge with rst_n=1).
//  - Simultaneous D and S change before an edge: the sampled values at the edge are used.
//  - No state machine; no handshake; no arithmetic.
// TESTING
//  - D=4'b1010, S=00,01,10,11 each held 20 ns -> Y=0,1,0,1; message "Teste completo" at end.
//  - D=4'b0101, sweep S -> Y=1,0,1,0; then D=4'b1111 with S=10 -> Y=1 without a clock edge.
//  - rst_n=0 at t=0 -> Y_q=0, sel_q=00 immediately; release, en=1, D=4'b1000, S=11 -> after 1 edge Y_q=1, sel_q=11.
//  - en=0, change S/D -> Y tracks at once, Y_q/sel_q unchanged over 3 edges.
//  - rst_n pulsed low between edges with Y_q=1 -> Y_q drops to 0 before the next edge.
//  - Exhaustive: all 16 D x 4 S -> Y equals D[S]; Y_q equals D[S] one edge later with en=1.

Source files
------------

// File: rtl/mux_comportamental.sv
// Behavioural lane-select multiplexer with a combinational output and
// an enabled, async-reset registered copy plus the select that produced it.
module mux_comportamental #(
  parameter int                 N_SEL   = 2,
  parameter int                 DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W*(2**N_SEL)-1:0]  D,
  input  logic [N_SEL-1:0]              S,
  input  logic                          en,
  output logic [DATA_W-1:0]             Y,
  output logic [DATA_W-1:0]             Y_q,
  output logic [N_SEL-1:0]              sel_q
);

  localparam int N_LANE = 2 ** N_SEL;

  logic [DATA_W-1:0] lanes [N_LANE];

  always_comb begin
    for (int i = 0; i < N_LANE; i++) begin
      lanes[i] = D[i*DATA_W +: DATA_W];
    end
  end

  // Array index: every S value maps to a lane, so no latch;
  // an unknown S yields X in four-state simulation.
  always_comb begin
    Y = lanes[S];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q   <= RST_VAL;
      sel_q <= '0;
    end else if (en) begin
      Y_q   <= lanes[S];
      sel_q <= S;
    end
  end

endmodule

// File: tb/tb_mux_comportamental.sv
// Directed checks of the 4:1 mux: combinational select,
// enabled capture, hold, async reset and an exhaustive sweep.
module tb_mux_comportamental;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic [1:0] S;
  logic       en;
  logic       Y;
  logic       Y_q;
  logic [1:0] sel_q;

  int tests;
  int fails;

  mux_comportamental dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .S     (S),
    .en    (en),
    .Y     (Y),
    .Y_q   (Y_q),
    .sel_q (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] ev;
    tests++;
    if (Y_q !== 1'b0) begin
      fails++;
      $display("FAIL reset_yq: got %b want 0", Y_q);
    end
    tests++;
    if (sel_q !== 2'b00) begin
      fails++;
      $display("FAIL reset_sel: got %b want 00", sel_q);
    end
    // reset must override en across an edge
    en = 1'b1;
    D  = 4'b1111;
    S  = 2'b11;
    @(posedge clk);
    #1;
    tests++;
    if (Y_q !== 1'b0 || sel_q !== 2'b00) begin
      fails++;
      $display("FAIL reset_hold: got %b/%b want 0/00", Y_q, sel_q);
    end
    ev = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    D = ev;
    S = 2'b11;
    #1;
    tests++;
    if (Y_q !== 1'b0) begin
      fails++;
      $display("FAIL release_no_edge: got %b want 0", Y_q);
    end
    @(posedge clk);
    #1;
    tests++;
    if (Y_q !== 1'b1 || sel_q !== 2'b11) begin
      fails++;
      $display("FAIL first_capture: got %b/%b want 1/11", Y_q, sel_q);
    end
  endtask

  task automatic test_sweep_1010();
    logic exp_y [4];
    exp_y = '{1'b0, 1'b1, 1'b0, 1'b1};
    en = 1'b0;
    D  = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1;
      tests++;
      if (Y !== exp_y[s]) begin
        fails++;
        $display("FAIL sweep_1010 s=%0d: got %b want %b", s, Y, exp_y[s]);
      end
      #19;
    end
  endtask

  task automatic test_sweep_0101();
    logic exp_y [4];
    exp_y = '{1'b1, 1'b0, 1'b1, 1'b0};
    en = 1'b0;
    D  = 4'b0101;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1;
      tests++;
      if (Y !== exp_y[s]) begin
        fails++;
        $display("FAIL sweep_0101 s=%0d: got %b want %b", s, Y, exp_y[s]);
      end
      #19;
    end
    @(negedge clk);
    D = 4'b1111;
    S = 2'b10;
    #1;
    tests++;
    if (Y !== 1'b1) begin
      fails++;
      $display("FAIL comb_no_clk: got %b want 1", Y);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b1;
    D  = 4'b1000;
    S  = 2'b11;
    @(posedge clk);
    #1;
    tests++;
    if (Y_q !== 1'b1 || sel_q !== 2'b11) begin
      fails++;
      $display("FAIL hold_setup: got %b/%b want 1/11", Y_q, sel_q);
    end
    @(negedge clk);
    en = 1'b0;
    D  = 4'b0000;
    S  = 2'b00;
    #1;
    tests++;
    if (Y !== 1'b0) begin
      fails++;
      $display("FAIL hold_comb: got %b want 0", Y);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (Y_q !== 1'b1 || sel_q !== 2'b11) begin
        fails++;
        $display("FAIL hold_edge%0d: got %b/%b want 1/11", k, Y_q, sel_q);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    tests++;
    if (Y_q !== 1'b1) begin
      fails++;
      $display("FAIL async_pre: got %b want 1", Y_q);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (Y_q !== 1'b0 || sel_q !== 2'b00) begin
      fails++;
      $display("FAIL async_drop: got %b/%b want 0/00", Y_q, sel_q);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive();
    logic [3:0] dv;
    logic [1:0] sv;
    logic       ey;
    en = 1'b1;
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        dv = 4'(d);
        sv = 2'(s);
        ey = dv[sv];
        @(negedge clk);
        D = dv;
        S = sv;
        #1;
        tests++;
        if (Y !== ey) begin
          fails++;
          $display("FAIL exh_y d=%h s=%0d: got %b want %b", dv, s, Y, ey);
        end
        @(posedge clk);
        #1;
        tests++;
        if (Y_q !== ey || sel_q !== sv) begin
          fails++;
          $display("FAIL exh_q d=%h s=%0d: got %b/%b want %b/%b",
                   dv, s, Y_q, sel_q, ey, sv);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    D     = 4'b0000;
    S     = 2'b00;
    #1;
    test_reset();
    test_sweep_1010();
    test_sweep_0101();
    test_hold();
    test_async_reset();
    test_exhaustive();
    $display("Teste completo");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
